// File: rtl/top_level.sv
// LFSR decryption engine: recovers the tap pattern and seed from the space preamble,
// then decrypts DM[64..127] into DM[0..63] and raises a sticky ack.

module data_mem #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          we
);
    logic [DW-1:0] core [0:(1<<AW)-1];

    assign rdata = core[raddr];

    always_ff @(posedge clk) begin
        if (we) core[waddr] <= wdata;
    end
endmodule

module top_level (
    input  logic clk,
    input  logic init,
    input  logic req,
    output logic ack
);
    localparam int unsigned AW       = 7;
    localparam int unsigned DW       = 8;
    localparam int unsigned KW       = 7;
    localparam int unsigned CW       = 7;
    localparam int unsigned PW       = 4;
    localparam int unsigned MSG_BASE = 64;
    localparam int unsigned MSG_LEN  = 64;
    localparam int unsigned PRE_MIN  = 10;
    localparam int unsigned NPTRN    = 9;

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECRYPT, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   k [0:PRE_MIN-1];
    logic [PW-1:0]   pidx;
    logic            found;
    logic [KW-1:0]   s;

    logic [AW-1:0]   mem_raddr;
    logic [DW-1:0]   mem_rdata;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_we;
    logic            match;
    logic            unused_parity;

    function automatic logic [KW-1:0] lfsr_step(input logic [KW-1:0] st, input logic [KW-1:0] p);
        return {st[KW-2:0], ^(st & p)};
    endfunction

    function automatic logic [KW-1:0] ptrn(input logic [PW-1:0] j);
        case (j)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            4'd8:    return 7'h7B;
            default: return 7'h60;
        endcase
    endfunction

    data_mem #(.AW(AW), .DW(DW)) DM (
        .clk   (clk),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .we    (mem_we)
    );

    assign unused_parity = mem_rdata[DW-1];

    // State register
    always_ff @(posedge clk) begin
        if (!init) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, memory controls and the candidate-pattern match for the current SEARCH slot
    always_comb begin
        state_nx  = state;
        mem_raddr = AW'(MSG_BASE) + cnt;
        mem_waddr = cnt;
        mem_wdata = {1'b0, mem_rdata[KW-1:0] ^ s};
        mem_we    = 1'b0;
        match     = 1'b1;

        for (int unsigned t = 0; t < PRE_MIN - 1; t++) begin
            if (lfsr_step(k[t], ptrn(cnt[PW-1:0])) != k[t+1]) match = 1'b0;
        end

        case (state)
            IDLE:    if (!req) state_nx = LOAD;
            LOAD:    if (cnt == CW'(PRE_MIN - 1)) state_nx = SEARCH;
            SEARCH:  if (cnt == CW'(NPTRN - 1)) state_nx = DECRYPT;
            DECRYPT: begin
                mem_we = 1'b1;
                if (cnt == CW'(MSG_LEN - 1)) state_nx = DONE;
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: phase counter, recovered keystream, chosen pattern, running LFSR state, ack
    always_ff @(posedge clk) begin
        if (!init) begin
            cnt   <= '0;
            pidx  <= '0;
            found <= 1'b0;
            s     <= '0;
            ack   <= 1'b0;
            for (int unsigned i = 0; i < PRE_MIN; i++) k[i] <= '0;
        end else begin
            ack <= (state == DONE);

            if (state != state_nx)
                cnt <= '0;
            else if ((state == LOAD || state == SEARCH || state == DECRYPT) && cnt != CW'(MSG_LEN - 1))
                cnt <= cnt + CW'(1);

            case (state)
                IDLE: begin
                    pidx  <= '0;
                    found <= 1'b0;
                end
                LOAD: k[cnt[PW-1:0]] <= mem_rdata[KW-1:0] ^ KW'(7'h20);
                SEARCH: begin
                    if (match && !found) begin
                        pidx  <= cnt[PW-1:0];
                        found <= 1'b1;
                    end
                    if (state_nx == DECRYPT) s <= k[0];
                end
                DECRYPT: s <= lfsr_step(s, ptrn(pidx));
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Randomized self-checking bench for top_level: encrypts messages with a known LFSR,
// predicts the recovered plaintext with a behavioural model and checks DM and ack timing.

module tb_top_level;
    logic clk = 1'b0;
    logic init = 1'b1;
    logic req = 1'b1;
    logic ack;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    localparam logic [6:0] ptrn_tab [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    logic [7:0] pt  [64];
    logic [7:0] enc [64];
    logic [7:0] exp_out [64];

    top_level dut (.clk(clk), .init(init), .req(req), .ack(ack));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [6:0] lstep(input logic [6:0] st, input logic [6:0] p);
        return {st[5:0], ^(st & p)};
    endfunction

    // Model: derive keystream from the known spaces, pick lowest consistent pattern, decrypt
    task automatic model();
        logic [6:0] ks [10];
        logic [6:0] st;
        int sel;
        bit ok;
        for (int t = 0; t < 10; t++) ks[t] = enc[t][6:0] ^ 7'h20;
        sel = -1;
        for (int j = 0; j < 9 && sel < 0; j++) begin
            st = ks[0];
            ok = 1'b1;
            for (int t = 1; t < 10; t++) begin
                st = lstep(st, ptrn_tab[j]);
                if (st != ks[t]) ok = 1'b0;
            end
            if (ok) sel = j;
        end
        if (sel < 0) sel = 0;
        st = ks[0];
        for (int i = 0; i < 64; i++) begin
            exp_out[i] = {1'b0, enc[i][6:0] ^ st};
            st = lstep(st, ptrn_tab[sel]);
        end
    endtask

    // Build padded plaintext, encrypt it, load DM and compute expectations
    task automatic prepare(input int pi, input logic [6:0] seed, input int npre,
                           input string msg, input int b7mode);
        logic [6:0] st;
        for (int i = 0; i < 64; i++) pt[i] = 8'h20;
        for (int i = 0; i < msg.len() && npre + i < 64; i++) pt[npre+i] = msg[i];
        st = seed;
        for (int i = 0; i < 64; i++) begin
            enc[i][6:0] = pt[i][6:0] ^ st;
            enc[i][7]   = (b7mode == 0) ? 1'b0 : (b7mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            st = lstep(st, ptrn_tab[pi]);
        end
        for (int i = 0; i < 64; i++) begin
            dut.DM.core[64+i] = enc[i];
            dut.DM.core[i]    = 8'hA5;
        end
        model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        init = 1'b0;
        req  = 1'b1;
        @(negedge clk);
        init = 1'b1;
    endtask

    // Start a run and measure edges from the req-sampling edge to ack
    task automatic run(input string tag);
        int n;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (ack === 1'b1) break;
        end
        chk({tag, ".latency"}, 32'(n), 32'd84);
        @(negedge clk);
        req = 1'b1;
    endtask

    task automatic verify(input string tag);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s.out[%0d]", tag, i), 32'(dut.DM.core[i]), 32'(exp_out[i]));
    endtask

    function automatic string rand_msg(input int maxlen);
        string m;
        int len;
        m = "";
        len = $urandom_range(0, maxlen);
        for (int i = 0; i < len; i++) m = {m, string'(8'($urandom_range(32, 126)))};
        return m;
    endfunction

    initial begin
        int ack_hi;
        int untouched;
        int xcnt;

        // Reset state
        do_reset();
        #1;
        chk("reset.ack", 32'(ack), 32'd0);

        // Known message, P=0x60 seed 0x01
        prepare(0, 7'h01, 10, "Knowledge comes, but wisdom lingers", 0);
        chk("fixed.enc64", 32'(dut.DM.core[64]), 32'h21);
        chk("fixed.enc65", 32'(dut.DM.core[65]), 32'h22);
        run("fixed");
        for (int i = 0; i < 10; i++) chk($sformatf("fixed.pre[%0d]", i), 32'(dut.DM.core[i]), 32'h20);
        chk("fixed.k", 32'(dut.DM.core[10]), 32'h4B);
        chk("fixed.n", 32'(dut.DM.core[11]), 32'h6E);
        for (int i = 0; i < 64; i++) chk($sformatf("fixed.pt[%0d]", i), 32'(dut.DM.core[i]), 32'(pt[i]));
        chk("fixed.src64", 32'(dut.DM.core[64]), 32'h21);
        chk("fixed.src65", 32'(dut.DM.core[65]), 32'h22);
        repeat (5) @(posedge clk);
        #1;
        chk("fixed.ack_sticky", 32'(ack), 32'd1);

        // req held high keeps the engine idle
        do_reset();
        prepare(3, 7'h35, 12, rand_msg(50), 1);
        ack_hi = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (ack !== 1'b0) ack_hi++;
        end
        chk("hold.ack_high_cycles", 32'(ack_hi), 32'd0);
        untouched = 0;
        for (int i = 0; i < 64; i++) if (dut.DM.core[i] === 8'hA5) untouched++;
        chk("hold.dm_untouched", 32'(untouched), 32'd64);
        run("hold");
        verify("hold");

        // Sweep every pattern with random seeds and preamble lengths
        for (int pi = 0; pi < 9; pi++) begin
            int npre;
            npre = $urandom_range(10, 15);
            do_reset();
            prepare(pi, 7'($urandom_range(1, 127)), npre, rand_msg(64 - npre), 1);
            run($sformatf("sweep%0d", pi));
            verify($sformatf("sweep%0d", pi));
        end

        // Reset mid-DECRYPT aborts, then a clean re-run
        do_reset();
        prepare(5, 7'h4D, 11, rand_msg(53), 1);
        @(negedge clk);
        req = 1'b0;
        repeat (41) @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        req  = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.ack", 32'(ack), 32'd0);
        @(negedge clk);
        init = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.idle_ack", 32'(ack), 32'd0);
        run("rerun");
        verify("rerun");

        // Long preamble, parity bits set on every input byte
        do_reset();
        prepare(7, 7'h13, 26, rand_msg(38), 2);
        run("par");
        verify("par");
        xcnt = 0;
        for (int i = 0; i < 128; i++) if ($isunknown(dut.DM.core[i])) xcnt++;
        chk("par.dm_x", 32'(xcnt), 32'd0);
        chk("par.ack_x", 32'($isunknown(ack)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
